// File: rtl/fwd_rollout_pkg.sv
// rtl/fwd_rollout_pkg.sv - shared types, width helpers and clip/shift function for forward_rollout_seq
//
// Contents:
//   state_t     - rollout FSM states
//   acc_w()     - accumulator width that cannot overflow for a row of products
//   idx_w()     - index width for a counter over n items (at least 1 bit)
//   clip_shift()- arithmetic right shift by frac, then clip to w bits
//
// Build option FWD_ROLLOUT_SAT_EN: when defined, clip_shift saturates to the
// signed w-bit range and reports it; otherwise it wraps to the low w bits.
package fwd_rollout_pkg;

    typedef enum logic [2:0] {
        IDLE,
        U_MAC,
        X_MAC,
        EMIT,
        DONE
    } state_t;

    // Working width of clip_shift; covers any accumulator for W up to ~28.
    localparam int ACC_MAX = 64;

    typedef struct packed {
        logic signed [ACC_MAX-1:0] val;
        logic                      sat;
    } clip_t;

    function automatic int acc_w(input int w, input int s, input int c);
        return 2 * w + $clog2(s + c) + 1;
    endfunction

    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Caller sign-extends its accumulator into v and keeps val[w-1:0].
    function automatic clip_t clip_shift(input logic signed [ACC_MAX-1:0] v,
                                         input int w, input int frac);
        clip_t                     r;
        logic signed [ACC_MAX-1:0] s;
        s     = v >>> frac;
        r.sat = 1'b0;
`ifdef FWD_ROLLOUT_SAT_EN
        begin
            logic signed [ACC_MAX-1:0] hi;
            logic signed [ACC_MAX-1:0] lo;
            hi = (64'sd1 <<< (w - 1)) - 64'sd1;
            lo = -(64'sd1 <<< (w - 1));
            if (s > hi) begin
                r.val = hi;
                r.sat = 1'b1;
            end else if (s < lo) begin
                r.val = lo;
                r.sat = 1'b1;
            end else begin
                r.val = s;
            end
        end
`else
        begin
            logic signed [ACC_MAX-1:0] mask;
            mask  = (64'sd1 <<< w) - 64'sd1;
            r.val = s & mask;
        end
`endif
        return r;
    endfunction

endpackage

// File: rtl/fp_mac.sv
// rtl/fp_mac.sv - signed W x W multiply-accumulate with shift-and-clip readout
//
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset (clears accumulator)
//   clr           clear accumulator on this edge (takes priority over en)
//   en            accumulate a*b on this edge
//   sub           1: acc -= a*b, 0: acc += a*b
//   a, b          signed W-bit operands
//   bias          signed ACC_W-bit term added to acc before readout only
//   res           clip((acc + bias) >>> FRAC), W bits, combinational
//   res_sat       res was clipped (only under FWD_ROLLOUT_SAT_EN)
module fp_mac
    import fwd_rollout_pkg::*;
#(
    parameter int W     = 16,
    parameter int ACC_W = 37,
    parameter int FRAC  = 0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    clr,
    input  logic                    en,
    input  logic                    sub,
    input  logic [W-1:0]            a,
    input  logic [W-1:0]            b,
    input  logic signed [ACC_W-1:0] bias,
    output logic [W-1:0]            res,
    output logic                    res_sat
);

    logic signed [ACC_W-1:0] acc;
    logic [2*W-1:0]          prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] sum;
    clip_t                   clipped;

    // Low 2W bits of the product of sign-extended operands equal the signed product.
    always_comb begin
        prod     = {{W{a[W-1]}}, a} * {{W{b[W-1]}}, b};
        prod_ext = {{(ACC_W-2*W){prod[2*W-1]}}, prod};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= sub ? (acc - prod_ext) : (acc + prod_ext);
        end
    end

    always_comb begin
        sum     = acc + bias;
        clipped = clip_shift({{(ACC_MAX-ACC_W){sum[ACC_W-1]}}, sum}, W, FRAC);
        res     = clipped.val[W-1:0];
        res_sat = clipped.sat;
    end

endmodule

// File: rtl/forward_rollout_seq.sv
// rtl/forward_rollout_seq.sv - multi-step closed-loop rollout u=-K x - d, x'=A x + B u on one MAC
//
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   start, n_steps, x0     start a rollout (IDLE only); n_steps clamped to HORIZON
//   d_seq, Kinf, A_mat, B_mat  operands read live; hold stable while busy
//   out_valid/out_ready    step result handshake; out_step, u_out, x_out hold until accepted
//   busy, done             rollout in progress / one-cycle end pulse
//   sat_flag               sticky clip indicator, cleared on start
//
// Build option FWD_ROLLOUT_SAT_EN selects saturating clip (else wrap, sat_flag=0).
module forward_rollout_seq
    import fwd_rollout_pkg::*;
#(
    parameter int STATE_DIM   = 12,
    parameter int CONTROL_DIM = 4,
    parameter int HORIZON     = 10,
    parameter int W           = 16,
    parameter int FRAC        = 0
) (
    input  logic                                          clk,
    input  logic                                          reset_n,
    input  logic                                          start,
    input  logic [$clog2(HORIZON+1)-1:0]                  n_steps,
    input  logic [STATE_DIM-1:0][W-1:0]                   x0,
    input  logic [HORIZON-1:0][CONTROL_DIM-1:0][W-1:0]    d_seq,
    input  logic [CONTROL_DIM-1:0][STATE_DIM-1:0][W-1:0]  Kinf,
    input  logic [STATE_DIM-1:0][STATE_DIM-1:0][W-1:0]    A_mat,
    input  logic [STATE_DIM-1:0][CONTROL_DIM-1:0][W-1:0]  B_mat,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [$clog2(HORIZON)-1:0]                    out_step,
    output logic [CONTROL_DIM-1:0][W-1:0]                 u_out,
    output logic [STATE_DIM-1:0][W-1:0]                   x_out,
    output logic                                          busy,
    output logic                                          done,
    output logic                                          sat_flag
);

    localparam int ACC_W = acc_w(W, STATE_DIM, CONTROL_DIM);
    localparam int NW    = $clog2(HORIZON + 1);
    localparam int KW    = $clog2(HORIZON);
    localparam int SW    = idx_w(STATE_DIM);
    localparam int CW    = idx_w(CONTROL_DIM);
    localparam int HW    = idx_w(HORIZON);
    localparam int LW    = idx_w(STATE_DIM + CONTROL_DIM + 1);

    state_t                      state;
    logic [SW-1:0]               row;
    logic [LW-1:0]               col;
    logic [NW-1:0]               k_reg;
    logic [NW-1:0]               n_reg;
    logic [NW-1:0]               n_clamped;
    logic [STATE_DIM-1:0][W-1:0] x_reg;

    // MAC control and operand selection
    logic                        mac_clr;
    logic                        mac_en;
    logic                        mac_sub;
    logic [W-1:0]                mac_a;
    logic [W-1:0]                mac_b;
    logic signed [ACC_W-1:0]     mac_bias;
    logic [W-1:0]                mac_res;
    logic                        mac_sat;
    logic                        wr;
    logic [LW-1:0]               bcol;
    logic [W-1:0]                dsel;
    logic signed [ACC_W-1:0]     d_ext;

    assign out_step  = k_reg[KW-1:0];
    assign n_clamped = (n_steps > NW'(HORIZON)) ? NW'(HORIZON) : n_steps;

    always_comb begin
        mac_clr  = 1'b0;
        mac_en   = 1'b0;
        mac_sub  = 1'b0;
        mac_a    = '0;
        mac_b    = '0;
        mac_bias = '0;
        wr       = 1'b0;
        bcol     = col - LW'(STATE_DIM);
        dsel     = d_seq[k_reg[HW-1:0]][row[CW-1:0]];
        d_ext    = {{(ACC_W-W){dsel[W-1]}}, dsel};
        case (state)
            U_MAC: begin
                if (col == LW'(STATE_DIM)) begin
                    // Write cycle: fold in the feedforward term at result scale.
                    mac_clr  = 1'b1;
                    wr       = 1'b1;
                    mac_bias = -(d_ext <<< FRAC);
                end else begin
                    mac_en  = 1'b1;
                    mac_sub = 1'b1;
                    mac_a   = Kinf[row[CW-1:0]][col[SW-1:0]];
                    mac_b   = x_reg[col[SW-1:0]];
                end
            end
            X_MAC: begin
                if (col == LW'(STATE_DIM + CONTROL_DIM)) begin
                    mac_clr = 1'b1;
                    wr      = 1'b1;
                end else if (col < LW'(STATE_DIM)) begin
                    mac_en = 1'b1;
                    mac_a  = A_mat[row][col[SW-1:0]];
                    mac_b  = x_reg[col[SW-1:0]];
                end else begin
                    // B uses the already-rounded W-bit u of this step.
                    mac_en = 1'b1;
                    mac_a  = B_mat[row][bcol[CW-1:0]];
                    mac_b  = u_out[bcol[CW-1:0]];
                end
            end
            default: ;
        endcase
    end

    fp_mac #(
        .W     (W),
        .ACC_W (ACC_W),
        .FRAC  (FRAC)
    ) u_mac (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (mac_clr),
        .en      (mac_en),
        .sub     (mac_sub),
        .a       (mac_a),
        .b       (mac_b),
        .bias    (mac_bias),
        .res     (mac_res),
        .res_sat (mac_sat)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            row       <= '0;
            col       <= '0;
            k_reg     <= '0;
            n_reg     <= '0;
            x_reg     <= '0;
            u_out     <= '0;
            x_out     <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sat_flag  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        x_reg    <= x0;
                        n_reg    <= n_clamped;
                        k_reg    <= '0;
                        sat_flag <= 1'b0;
                        row      <= '0;
                        col      <= '0;
                        if (n_clamped == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= U_MAC;
                            busy  <= 1'b1;
                        end
                    end
                end
                U_MAC: begin
                    if (wr) begin
                        u_out[row[CW-1:0]] <= mac_res;
                        sat_flag           <= sat_flag | mac_sat;
                        col                <= '0;
                        if (row == SW'(CONTROL_DIM - 1)) begin
                            row   <= '0;
                            state <= X_MAC;
                        end else begin
                            row <= row + SW'(1);
                        end
                    end else begin
                        col <= col + LW'(1);
                    end
                end
                X_MAC: begin
                    if (wr) begin
                        x_out[row] <= mac_res;
                        sat_flag   <= sat_flag | mac_sat;
                        col        <= '0;
                        if (row == SW'(STATE_DIM - 1)) begin
                            row       <= '0;
                            state     <= EMIT;
                            out_valid <= 1'b1;
                        end else begin
                            row <= row + SW'(1);
                        end
                    end else begin
                        col <= col + LW'(1);
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        x_reg     <= x_out;
                        k_reg     <= k_reg + NW'(1);
                        if (k_reg + NW'(1) == n_reg) begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state <= U_MAC;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
